// File: rtl/ram_bist_master_if.sv
// RAM-side Avalon port of the BIST master: master drives address/controls,
// slave returns registered read data.
interface ram_bist_master_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) ();
    logic [ADDR_W-1:0]   ram_address;
    logic [DATA_W/8-1:0] ram_byteenable;
    logic                ram_chipselect;
    logic                ram_write;
    logic [DATA_W-1:0]   ram_writedata;
    logic                ram_clken;
    logic [DATA_W-1:0]   ram_readdata;

    modport master (
        output ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata, ram_clken,
        input  ram_readdata
    );

    modport slave (
        input  ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata, ram_clken,
        output ram_readdata
    );
endinterface

// File: rtl/ram_bist_master.sv
// Four-phase write/read-compare march over the whole system RAM with
// saturating error count and first-failure capture.
module ram_bist_master #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ERR_W  = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start_i,
    input  logic [DATA_W-1:0]   seed_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                pass_o,
    output logic [ERR_W-1:0]    err_count_o,
    output logic [ADDR_W-1:0]   fail_addr_o,
    output logic [DATA_W-1:0]   fail_data_o,
    ram_bist_master_if.master   ram_if
);

    typedef enum logic [2:0] {
        StIdle, StFill, StCheck, StDrain, StFillInv, StCheckInv, StDrainInv, StDone
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   seed_q, seed_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0]   fail_data_q, fail_data_d;
    logic                pass_q, pass_d;
    logic                busy_q, done_q, cs_q, wr_q;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                cmp_q;
    logic [DATA_W-1:0]   exp_q, exp_d;
    logic                start_acc, last, mismatch;
    logic                fill_d, check_d, inv_d;

    assign start_acc = (state_q == StIdle) && start_i;
    assign last      = &cnt_q;
    assign mismatch  = cmp_q && (ram_if.ram_readdata != exp_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        seed_d  = seed_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StFill;
                    cnt_d   = '0;
                    seed_d  = seed_i;
                end
            end
            StFill: begin
                cnt_d = cnt_q + 1'b1;
                if (last) state_d = StCheck;
            end
            StCheck: begin
                cnt_d = cnt_q + 1'b1;
                if (last) state_d = StDrain;
            end
            StDrain:    state_d = StFillInv;
            StFillInv: begin
                cnt_d = cnt_q + 1'b1;
                if (last) state_d = StCheckInv;
            end
            StCheckInv: begin
                cnt_d = cnt_q + 1'b1;
                if (last) state_d = StDrainInv;
            end
            StDrainInv: state_d = StDone;
            StDone:     state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Port controls are registered from the next state so they line up with cnt_q.
    always_comb begin
        fill_d  = (state_d == StFill) || (state_d == StFillInv);
        check_d = (state_d == StCheck) || (state_d == StCheckInv);
        inv_d   = (state_d == StFillInv) || (state_d == StCheckInv);
        wdata_d = wdata_q;
        if (fill_d) wdata_d = inv_d ? ~(seed_d ^ DATA_W'(cnt_d)) : (seed_d ^ DATA_W'(cnt_d));
        exp_d   = (state_q == StCheckInv) ? ~(seed_q ^ DATA_W'(cnt_q)) : (seed_q ^ DATA_W'(cnt_q));
    end

    always_comb begin
        err_d       = err_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        pass_d      = pass_q;
        if (start_acc) begin
            err_d       = '0;
            fail_addr_d = '0;
            fail_data_d = '0;
            pass_d      = 1'b0;
        end else if (mismatch) begin
            if (!(&err_q)) err_d = err_q + 1'b1;
            if (err_q == '0) begin
                fail_addr_d = cnt_q - 1'b1;
                fail_data_d = ram_if.ram_readdata;
            end
        end
        if (state_d == StDone) pass_d = (err_d == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            seed_q      <= '0;
            err_q       <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            pass_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cs_q        <= 1'b0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            cmp_q       <= 1'b0;
            exp_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            seed_q      <= seed_d;
            err_q       <= err_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            pass_q      <= pass_d;
            busy_q      <= (state_d != StIdle) && (state_d != StDone);
            done_q      <= (state_d == StDone);
            cs_q        <= fill_d || check_d;
            wr_q        <= fill_d;
            wdata_q     <= wdata_d;
            cmp_q       <= (state_q == StCheck) || (state_q == StCheckInv);
            exp_q       <= exp_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign err_count_o = err_q;
    assign fail_addr_o = fail_addr_q;
    assign fail_data_o = fail_data_q;

    assign ram_if.ram_address    = cnt_q;
    assign ram_if.ram_byteenable = '1;
    assign ram_if.ram_chipselect = cs_q;
    assign ram_if.ram_write      = wr_q;
    assign ram_if.ram_writedata  = wdata_q;
    assign ram_if.ram_clken      = 1'b1;

endmodule

// File: tb/tb_ram_bist_master.sv
// Bench for ram_bist_master: RAM model with read-side stuck-at fault injection,
// randomized seeds/faults scored against a per-address march model.
module tb_ram_bist_master;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ERR_W  = 8;
    localparam int          DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [DATA_W-1:0] seed;
    logic              busy, done, pass;
    logic [ERR_W-1:0]  err_count;
    logic [ADDR_W-1:0] fail_addr;
    logic [DATA_W-1:0] fail_data;

    int n_checks = 0;
    int n_errors = 0;

    ram_bist_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_bist_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ERR_W(ERR_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_i     (start),
        .seed_i      (seed),
        .busy_o      (busy),
        .done_o      (done),
        .pass_o      (pass),
        .err_count_o (err_count),
        .fail_addr_o (fail_addr),
        .fail_data_o (fail_data),
        .ram_if      (bus)
    );

    always #5 clk = ~clk;

    // RAM: zero wait states, read data registered; s1/s0 force read bits high/low.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] s1  [DEPTH];
    logic [DATA_W-1:0] s0  [DEPTH];
    logic [DATA_W-1:0] rd_q;
    logic [ADDR_W-1:0] rd_addr_q = '0;

    always @(posedge clk) begin
        if (bus.ram_chipselect && bus.ram_clken) begin
            if (bus.ram_write) mem[bus.ram_address] <= bus.ram_writedata;
            else begin
                rd_q      <= mem[bus.ram_address];
                rd_addr_q <= bus.ram_address;
            end
        end
    end

    assign bus.ram_readdata = (rd_q | s1[rd_addr_q]) & ~s0[rd_addr_q];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_faults();
        for (int a = 0; a < DEPTH; a++) begin
            s1[a] = '0;
            s0[a] = '0;
        end
    endtask

    // Walk both march passes address by address and apply the fault masks.
    task automatic model_expect(input logic [31:0] s, output int errs,
                                output logic [ADDR_W-1:0] fa, output logic [DATA_W-1:0] fd);
        errs = 0;
        fa   = '0;
        fd   = '0;
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < DEPTH; a++) begin
                logic [DATA_W-1:0] w, r;
                w = s ^ DATA_W'(a);
                if (p == 1) w = ~w;
                r = (w | s1[a]) & ~s0[a];
                if (r != w) begin
                    if (errs == 0) begin
                        fa = ADDR_W'(a);
                        fd = r;
                    end
                    errs++;
                end
            end
        end
    endtask

    task automatic run_test(input logic [31:0] s, input int reset_at, input bit inject_start);
        int                errs, cyc, n_wr, n_idle_cs;
        bit                be_bad, bsy_bad, seen_done, aborted;
        logic [ADDR_W-1:0] exp_fa;
        logic [DATA_W-1:0] exp_fd;
        logic [31:0]       exp_w5;

        model_expect(s, errs, exp_fa, exp_fd);
        if (errs > 255) errs = 255;
        n_wr = 0; n_idle_cs = 0; be_bad = 0; bsy_bad = 0; seen_done = 0; aborted = 0;

        @(posedge clk); #1;
        seed  = s;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seed  = $urandom;
        cyc   = 1;
        check_val("start_busy", {63'd0, busy}, 64'd1);
        check_val("start_clears_pass", {63'd0, pass}, 64'd0);
        check_val("start_clears_err", {56'd0, err_count}, 64'd0);

        while (cyc < 5000) begin
            if (done) begin
                seen_done = 1;
                break;
            end
            if (bus.ram_write) n_wr++;
            if (busy && !bus.ram_chipselect) n_idle_cs++;
            if (bus.ram_byteenable != 4'hF || bus.ram_clken != 1'b1) be_bad = 1;
            if (!busy) bsy_bad = 1;
            if (cyc == reset_at) begin
                reset_n = 1'b0;
                #1;
                check_val("rst_busy", {63'd0, busy}, 64'd0);
                check_val("rst_cs", {63'd0, bus.ram_chipselect}, 64'd0);
                check_val("rst_write", {63'd0, bus.ram_write}, 64'd0);
                @(posedge clk); #1;
                reset_n = 1'b1;
                aborted = 1;
                break;
            end
            if (inject_start && cyc == 500) begin
                start = 1'b1;
                seed  = '1;
            end
            if (inject_start && cyc == 501) start = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end

        if (aborted) begin
            for (int i = 0; i < 20; i++) begin
                if (done || busy) seen_done = 1;
                @(posedge clk); #1;
            end
            check_val("rst_no_done", {63'd0, seen_done}, 64'd0);
            return;
        end

        check_val("done_seen", {63'd0, seen_done}, 64'd1);
        check_val("done_cycle", 64'(cyc), 64'(4 * DEPTH + 3));
        check_val("done_busy_low", {63'd0, busy}, 64'd0);
        check_val("write_cycles", 64'(n_wr), 64'(2 * DEPTH));
        check_val("drain_cs_low", 64'(n_idle_cs), 64'd2);
        check_val("byteen_clken", {63'd0, be_bad}, 64'd0);
        check_val("busy_held", {63'd0, bsy_bad}, 64'd0);
        check_val("pass", {63'd0, pass}, {63'd0, errs == 0});
        check_val("err_count", {56'd0, err_count}, 64'(errs));
        check_val("fail_addr", {54'd0, fail_addr}, {54'd0, exp_fa});
        check_val("fail_data", {32'd0, fail_data}, {32'd0, exp_fd});
        exp_w5 = ~(s ^ 32'd5);
        check_val("ram5", {32'd0, mem[5]}, {32'd0, exp_w5});
        @(posedge clk); #1;
        check_val("done_pulse", {63'd0, done}, 64'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        seed    = '0;
        clear_faults();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_state_busy", {63'd0, busy}, 64'd0);
        check_val("rst_state_done", {63'd0, done}, 64'd0);
        check_val("rst_state_pass", {63'd0, pass}, 64'd0);
        check_val("rst_state_err", {56'd0, err_count}, 64'd0);
        check_val("rst_state_faddr", {54'd0, fail_addr}, 64'd0);
        check_val("rst_state_fdata", {32'd0, fail_data}, 64'd0);
        check_val("rst_state_addr", {54'd0, bus.ram_address}, 64'd0);
        check_val("rst_state_wdata", {32'd0, bus.ram_writedata}, 64'd0);
        check_val("rst_state_cs", {63'd0, bus.ram_chipselect}, 64'd0);
        check_val("rst_state_wr", {63'd0, bus.ram_write}, 64'd0);
        check_val("rst_state_be", {60'd0, bus.ram_byteenable}, 64'hF);
        check_val("rst_state_clken", {63'd0, bus.ram_clken}, 64'd1);
        reset_n = 1'b1;

        run_test(32'h0, -1, 0);
        check_val("clean_ram5", {32'd0, mem[5]}, 64'hFFFF_FFFA);

        s1[3] = 32'h1;
        run_test(32'hA5A5_A5A5, -1, 0);
        check_val("stuck_data", {32'd0, fail_data}, 64'hA5A5_A5A7);
        clear_faults();

        for (int a = 0; a < DEPTH; a++) s0[a] = '1;
        run_test(32'h0, -1, 0);
        check_val("sat_count", {56'd0, err_count}, 64'd255);
        clear_faults();

        run_test(32'h0, -1, 1);

        run_test($urandom, 2000, 0);
        run_test($urandom, -1, 0);

        for (int k = 0; k < 3; k++) begin
            int nf;
            nf = $urandom_range(0, 3);
            for (int f = 0; f < nf; f++) begin
                int a;
                a = $urandom_range(0, DEPTH - 1);
                if ($urandom_range(0, 1) == 1) s1[a] = s1[a] | (32'h1 << $urandom_range(0, 31));
                else                           s0[a] = s0[a] | (32'h1 << $urandom_range(0, 31));
            end
            run_test($urandom, -1, 0);
            clear_faults();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ram_bist_master.md
# ram_bist_master

Built-in self-test master for the on-chip 32-bit single-port system RAM. The block sits directly upstream of the RAM's Avalon slave port and drives the RAM's address, write, byteenable and clken inputs. It performs a four-phase write/read-compare march over every word and reports pass/fail, error count and the first failing location. The integrator muxes the RAM port to this block while `busy` is high; otherwise the CPU owns it.

## Interface
Parameters:
- `ADDR_W`, 10, word-address width; the test covers all `DEPTH = 2**ADDR_W` words
- `DATA_W`, 32, RAM data width; byteenable width is `DATA_W/8`
- `ERR_W`, 16, width of the saturating error counter

Ports:
- `clk`  in  1  single clock, shared with the RAM
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request; honoured only in IDLE
- `seed`  in  DATA_W  pattern seed, captured on an accepted `start`
- `busy`  out  1  high from the cycle after an accepted `start` through the last drain cycle
- `done`  out  1  one-cycle pulse when the test completes
- `pass`  out  1  1 when `err_count == 0`; valid from `done` until the next accepted `start`
- `err_count`  out  ERR_W  mismatching reads, saturating at all-ones
- `fail_addr`  out  ADDR_W  address of the first mismatch
- `fail_data`  out  DATA_W  read data of the first mismatch
- `ram_address`  out  ADDR_W  RAM word address
- `ram_byteenable`  out  DATA_W/8  always all-ones
- `ram_chipselect`  out  1  high during FILL/CHECK issue cycles only
- `ram_write`  out  1  high during FILL issue cycles only
- `ram_writedata`  out  DATA_W  write pattern
- `ram_clken`  out  1  tied 1
- `ram_readdata`  in  DATA_W  RAM read data, valid the cycle after the read address is issued

## Operation
- Pattern: `P(a) = seed_q ^ zero_extend(a)`.
- The FSM runs `IDLE -> FILL -> CHECK -> DRAIN -> FILL_INV -> CHECK_INV -> DRAIN_INV -> DONE -> IDLE`.
- FILL: writes `P(a)` for a = 0..DEPTH-1, one word per cycle, ascending.
- CHECK: reads a = 0..DEPTH-1, one per cycle. Expected data and address are delayed one cycle and compared against `ram_readdata` in the following cycle. DRAIN performs the compare for the last address only, with `ram_chipselect = 0`.
- FILL_INV and CHECK_INV: same as FILL and CHECK using `~P(a)`.
- Mismatch handling: any bit mismatch increments `err_count`, saturating at `2**ERR_W-1`. The first mismatch since `start` latches `fail_addr`/`fail_data`; later mismatches do not overwrite them.
- DONE: asserts `done` for one cycle, `busy` = 0, updates `pass`, then returns to IDLE.
- Accepted `start`: clears `err_count`, `fail_addr`, `fail_data` and `pass`, and captures `seed`.
- `start` while not in IDLE is ignored, and `seed` is not re-captured.
- Address counter is ADDR_W bits wide. The phase advances when the counter equals DEPTH-1 and the counter wraps to 0.
- Reset values: state IDLE; `busy`/`done`/`pass`/`ram_chipselect`/`ram_write` = 0; `err_count`, `fail_addr`, `fail_data`, `ram_address` and `ram_writedata` = 0; `ram_byteenable` all-ones; `ram_clken` = 1.
- Reset mid-test: returns immediately to the reset values. RAM contents are undefined and no `done` is generated.

## Timing
- All RAM-side outputs are registered. `start` sampled high at edge t0 in IDLE puts FILL address 0 on the port in cycle 1.
- Issue cycles:
  - FILL: 1..DEPTH
  - CHECK: DEPTH+1..2·DEPTH
  - DRAIN: 2·DEPTH+1
  - FILL_INV: 2·DEPTH+2..3·DEPTH+1
  - CHECK_INV: 3·DEPTH+2..4·DEPTH+1
  - DRAIN_INV: 4·DEPTH+2
- `done` is high in cycle 4·DEPTH+3, which is 4099 for ADDR_W = 10.
- Compare for a read issued in cycle n uses `ram_readdata` in cycle n+1. `err_count`/`fail_*` update at the end of cycle n+1.
- No stalls: the RAM slave has zero wait states and `ram_clken` stays high.

## Test plan
- **Clean run:** seed=0, ideal RAM model, `start` at t0 -> `done` in cycle 4099, `pass`=1, `err_count`=0; afterwards RAM[5]=0xFFFFFFFA.
- **Stuck-at fault:** seed=0xA5A5A5A5, model forces `ram_readdata[0]`=1 for address 3 -> CHECK reads 0xA5A5A5A7 ≠ 0xA5A5A5A6; CHECK_INV matches 0x5A5A5A59. Result: `err_count`=1, `fail_addr`=3, `fail_data`=0xA5A5A5A7, `pass`=0.
- **Saturation:** ERR_W=8, seed=0, `ram_readdata` forced to 0 -> 2047 mismatches with only address 0 in CHECK matching; `err_count`=255, `fail_addr`=1, `fail_data`=0, `pass`=0.
- **Start while busy:** pulse `start` with seed=0xFFFFFFFF in cycle 500 of a seed=0 run -> ignored; `done` still at 4099 and RAM[5]=0xFFFFFFFA.
- **Reset mid-op:** assert `reset_n`=0 in cycle 2000 -> same cycle `busy`=0, `ram_chipselect`=0, `ram_write`=0; no `done`. A fresh `start` after release completes normally with `pass`=1.
- **Handshake check:** `ram_chipselect` is low in both DRAIN cycles, `ram_write` is high for exactly 2·DEPTH cycles, and `ram_byteenable`=4'hF throughout.
